// File: rtl/ips_bram_tdp_be_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ips_bram_tdp_be_if : two-port byte-enable BRAM access bundle       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ips_bram_tdp_be_if #(
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32
);
  localparam int NB_BRAM_BYT = WD_BRAM_DAT / 8;

  logic                   ena;
  logic [NB_BRAM_BYT-1:0] wea;
  logic [WD_BRAM_ADR-1:0] addra;
  logic [WD_BRAM_DAT-1:0] dina;
  logic [WD_BRAM_DAT-1:0] douta;
  logic                   vlda;

  logic                   enb;
  logic [NB_BRAM_BYT-1:0] web;
  logic [WD_BRAM_ADR-1:0] addrb;
  logic [WD_BRAM_DAT-1:0] dinb;
  logic [WD_BRAM_DAT-1:0] doutb;
  logic                   vldb;

  modport master (
    output ena, wea, addra, dina, enb, web, addrb, dinb,
    input  douta, vlda, doutb, vldb
  );

  modport slave (
    input  ena, wea, addra, dina, enb, web, addrb, dinb,
    output douta, vlda, doutb, vldb
  );
endinterface
`default_nettype wire

// File: rtl/ips_bram_tdp_be.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ips_bram_tdp_be : single-clock true-dual-port byte-enable BRAM     |
// | with read pipeline, collision counter and post-reset clear sweep.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ips_bram_tdp_be #(
  parameter int NB_BRAM_DLY = 2,
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32,
  parameter int RD_WR_MODE  = 0,
  parameter int WD_COLL_CNT = 16
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  ips_bram_tdp_be_if.slave       s_bram_0,
  output logic                   o_init_busy,
  output logic [WD_COLL_CNT-1:0] o_coll_cnt
);
  localparam int NB_BRAM_BYT = WD_BRAM_DAT / 8;
  localparam int NB_BRAM_ADR = 2 ** WD_BRAM_ADR;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [WD_BRAM_ADR-1:0] sweep_addr, sweep_nxt;

  logic                   en     [2];
  logic [NB_BRAM_BYT-1:0] we     [2];
  logic [WD_BRAM_ADR-1:0] addr   [2];
  logic [WD_BRAM_DAT-1:0] din    [2];
  logic [WD_BRAM_DAT-1:0] rd_word[2];
  logic                   issue  [2];
  logic [WD_BRAM_DAT-1:0] tail_dat[2];
  logic                   tail_vld[2];
  logic [WD_BRAM_DAT-1:0] dout   [2];
  logic                   vld    [2];
  logic                   coll;

  logic [WD_BRAM_DAT-1:0] mem [NB_BRAM_ADR];

  assign en[0]   = s_bram_0.ena;
  assign we[0]   = s_bram_0.wea;
  assign addr[0] = s_bram_0.addra;
  assign din[0]  = s_bram_0.dina;
  assign en[1]   = s_bram_0.enb;
  assign we[1]   = s_bram_0.web;
  assign addr[1] = s_bram_0.addrb;
  assign din[1]  = s_bram_0.dinb;

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sweep_nxt   = sweep_addr;
    o_init_busy = 1'b0;
    case (state)
      ST_INIT: begin
        o_init_busy = 1'b1;
        sweep_nxt   = sweep_addr + 1'b1;
        if (sweep_addr == '1) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Port B is written first so port A's later assignment wins on shared lanes
  always_ff @(posedge i_sys_clk) begin
    if (state == ST_INIT) begin
      mem[sweep_addr] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int k = 0; k < NB_BRAM_BYT; k++) begin
          if (en[p] && we[p][k]) mem[addr[p]][8*k +: 8] <= din[p][8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[addr[p]];
      issue[p]   = (state == ST_RUN) && en[p] &&
                   !((RD_WR_MODE == 2) && (we[p] != '0));
      if (RD_WR_MODE == 0) begin
        for (int k = 0; k < NB_BRAM_BYT; k++) begin
          if (we[p][k]) rd_word[p][8*k +: 8] = din[p][8*k +: 8];
        end
      end
    end
    coll = (state == ST_RUN) && en[0] && en[1] && (addr[0] == addr[1]) &&
           ((we[0] & we[1]) != '0);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      o_coll_cnt <= '0;
    end else if (coll && (o_coll_cnt != '1)) begin
      o_coll_cnt <= o_coll_cnt + 1'b1;
    end
  end

  if (NB_BRAM_DLY == 1) begin : g_dly1
    always_comb begin
      for (int p = 0; p < 2; p++) begin
        tail_dat[p] = rd_word[p];
        tail_vld[p] = issue[p];
      end
    end
  end else begin : g_dlyn
    logic [WD_BRAM_DAT-1:0] stg_dat [2][NB_BRAM_DLY-1];
    logic [NB_BRAM_DLY-2:0] stg_vld [2];

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
        for (int p = 0; p < 2; p++) begin
          stg_vld[p] <= '0;
          for (int i = 0; i < NB_BRAM_DLY - 1; i++) stg_dat[p][i] <= '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          stg_dat[p][0] <= rd_word[p];
          stg_vld[p][0] <= issue[p];
          for (int i = 1; i < NB_BRAM_DLY - 1; i++) begin
            stg_dat[p][i] <= stg_dat[p][i-1];
            stg_vld[p][i] <= stg_vld[p][i-1];
          end
        end
      end
    end

    always_comb begin
      for (int p = 0; p < 2; p++) begin
        tail_dat[p] = stg_dat[p][NB_BRAM_DLY-2];
        tail_vld[p] = stg_vld[p][NB_BRAM_DLY-2];
      end
    end
  end

  // Output register holds the last valid word across idle slots
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      for (int p = 0; p < 2; p++) begin
        dout[p] <= '0;
        vld[p]  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld[p] <= tail_vld[p];
        if (tail_vld[p]) dout[p] <= tail_dat[p];
      end
    end
  end

  assign s_bram_0.douta = dout[0];
  assign s_bram_0.vlda  = vld[0];
  assign s_bram_0.doutb = dout[1];
  assign s_bram_0.vldb  = vld[1];
endmodule
`default_nettype wire
